// File: rtl/nested_loop_counter.sv
// nested_loop_counter
//   Two-level nested loop counter for FIR tap and CNN kernel/window address
//   generation. The inner index sweeps 0..inner limit; each time it wraps, the
//   outer index steps, until both reach their limits. Limits are inclusive and
//   latched when a run is accepted.
//
//   Optional feature macro: NESTED_LOOP_COUNTER_RESTART_EN
//     defined   : start_i during a run aborts it (no done_o) and restarts at
//                 (0,0) with freshly latched limits. Restart beats stall_i and
//                 the final-beat advance.
//     undefined : start_i is ignored while busy_o is high.
//
// Ports
//   clk_i         clock
//   reset_i       asynchronous, active-high reset
//   start_i       start request, sampled while idle
//   stall_i       hold the current beat
//   inner_max_i   inner limit (inclusive), latched on accepted start
//   outer_max_i   outer limit (inclusive), latched on accepted start
//   valid_o       current index pair is a valid beat
//   inner_o       inner index
//   outer_o       outer index
//   last_inner_o  valid beat with inner index at its limit
//   last_o        valid final beat of the run
//   busy_o        run in progress
//   done_o        one-cycle pulse after the final beat advances
//
// state | meaning
// IDLE  | no run; waiting for start_i, indices held at 0
// COUNT | presenting beats; valid_o = busy_o = 1

module nested_loop_counter #(
    parameter int INNER_WIDTH = 8,
    parameter int OUTER_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   stall_i,
    input  logic [INNER_WIDTH-1:0] inner_max_i,
    input  logic [OUTER_WIDTH-1:0] outer_max_i,
    output logic                   valid_o,
    output logic [INNER_WIDTH-1:0] inner_o,
    output logic [OUTER_WIDTH-1:0] outer_o,
    output logic                   last_inner_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t                 state;
    logic [INNER_WIDTH-1:0] inner_lim;
    logic [OUTER_WIDTH-1:0] outer_lim;

    logic inner_end;
    logic outer_end;
    logic advance;

    // Equality against the latched limits only; no limit-1 arithmetic, so an
    // all-ones limit never wraps early.
    assign inner_end = (inner_o == inner_lim);
    assign outer_end = (outer_o == outer_lim);
    assign advance   = valid_o && !stall_i;

    assign last_inner_o = valid_o && inner_end;
    assign last_o       = valid_o && inner_end && outer_end;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            inner_o   <= '0;
            outer_o   <= '0;
            inner_lim <= '0;
            outer_lim <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        inner_lim <= inner_max_i;
                        outer_lim <= outer_max_i;
                        inner_o   <= '0;
                        outer_o   <= '0;
                        valid_o   <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= COUNT;
                    end
                end
                COUNT: begin
`ifdef NESTED_LOOP_COUNTER_RESTART_EN
                    if (start_i) begin
                        inner_lim <= inner_max_i;
                        outer_lim <= outer_max_i;
                        inner_o   <= '0;
                        outer_o   <= '0;
                    end else if (advance) begin
`else
                    if (advance) begin
`endif
                        if (inner_end) begin
                            inner_o <= '0;
                            if (outer_end) begin
                                // Final beat consumed: leave with a done pulse.
                                outer_o <= '0;
                                valid_o <= 1'b0;
                                busy_o  <= 1'b0;
                                done_o  <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                outer_o <= outer_o + OUTER_WIDTH'(1);
                            end
                        end else begin
                            inner_o <= inner_o + INNER_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
